// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap controller for the 32-bit core.
// Latency: csr_rdata/illegal are combinational; trap_valid/trap_target are registered
//    (one-cycle pulse on the edge after the trapping, or MRET, instruction).
// Backpressure: none; every presented instruction is resolved in the cycle it is valid.
// Optional feature: define CSR_IRQ_SYNC_EN to add a 2-flop synchroniser in front of mip.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   pc, instr_valid     boundary instruction pc and retire strobe
//   csr_op, csr_imm_sel, csr_zimm, rs1_data, csr_addr   CSR/system operation
//   irq_sw, irq_tim, irq_ext, irq_plat                  level interrupt requests
//   csr_rdata, illegal  combinational read data and illegal-access flag
//   trap_valid, trap_target  registered fetch redirect
module csr_trap_unit #(
   parameter int          NUM_IRQ   = 4,
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        pc,
   input  logic               instr_valid,
   input  logic [2:0]         csr_op,
   input  logic               csr_imm_sel,
   input  logic [4:0]         csr_zimm,
   input  logic [31:0]        rs1_data,
   input  logic [11:0]        csr_addr,
   input  logic               irq_sw,
   input  logic               irq_tim,
   input  logic               irq_ext,
   input  logic [NUM_IRQ-1:0] irq_plat,
   output logic [31:0]        csr_rdata,
   output logic               illegal,
   output logic               trap_valid,
   output logic [31:0]        trap_target
);

   localparam logic [31:0] PLAT_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << 16;
   localparam logic [31:0] IRQ_MASK  = PLAT_MASK | 32'h0000_0888;

   localparam logic [2:0] OP_RW    = 3'b001;
   localparam logic [2:0] OP_RS    = 3'b010;
   localparam logic [2:0] OP_RC    = 3'b011;
   localparam logic [2:0] OP_ECALL = 3'b100;
   localparam logic [2:0] OP_EBRK  = 3'b101;
   localparam logic [2:0] OP_MRET  = 3'b110;

   // architectural state
   logic        mstat_mie;
   logic        mstat_mpie;
   logic [31:0] mie_r;
   logic [31:0] mtvec;
   logic [31:0] mscratch;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mtval;
   logic [31:0] mip_q;
   logic [63:0] mcycle;
   logic [63:0] minstret;

   // interrupt requests laid out in mip bit positions
   logic [31:0] irq_raw;
   logic [31:0] irq_in;

   always_comb begin
      irq_raw                 = '0;
      irq_raw[3]              = irq_sw;
      irq_raw[7]              = irq_tim;
      irq_raw[11]             = irq_ext;
      irq_raw[16 +: NUM_IRQ]  = irq_plat;
   end

`ifdef CSR_IRQ_SYNC_EN
   logic [31:0] sync1;
   logic [31:0] sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= irq_raw;
         sync2 <= sync1;
      end
   end

   assign irq_in = sync2;
`else
   assign irq_in = irq_raw;
`endif

   // decode and read mux
   logic        is_csr;
   logic        known;
   logic        read_only;
   logic        do_write;
   logic [31:0] src;
   logic [31:0] old_val;
   logic [31:0] new_val;

   assign is_csr = (csr_op == OP_RW) || (csr_op == OP_RS) || (csr_op == OP_RC);
   assign src    = csr_imm_sel ? {27'b0, csr_zimm} : rs1_data;

   always_comb begin
      old_val = '0;
      known   = 1'b1;
      case (csr_addr)
         12'h300: old_val = {19'b0, 2'b11, 3'b0, mstat_mpie, 3'b0, mstat_mie, 3'b0};
         12'h301: old_val = 32'h4000_0100;
         12'h304: old_val = mie_r;
         12'h305: old_val = mtvec;
         12'h340: old_val = mscratch;
         12'h341: old_val = mepc;
         12'h342: old_val = mcause;
         12'h343: old_val = mtval;
         12'h344: old_val = mip_q;
         12'hB00: old_val = mcycle[31:0];
         12'hB80: old_val = mcycle[63:32];
         12'hB02: old_val = minstret[31:0];
         12'hB82: old_val = minstret[63:32];
         12'hF14: old_val = 32'h0;
         default: known   = 1'b0;
      endcase
   end

   // RS/RC with a zero source are pure reads and never write
   assign do_write  = (csr_op == OP_RW) || (src != 32'h0);
   assign read_only = (csr_addr[11:10] == 2'b11) || (csr_addr == 12'h301) || (csr_addr == 12'h344);
   assign illegal   = is_csr && (!known || (read_only && do_write));
   assign csr_rdata = is_csr ? old_val : 32'h0;

   always_comb begin
      case (csr_op)
         OP_RS:   new_val = old_val | src;
         OP_RC:   new_val = old_val & ~src;
         default: new_val = src;
      endcase
   end

   // interrupt arbitration: later assignments win, so the order below runs
   // from lowest to highest priority
   logic [31:0] pend;
   logic        irq_take;
   logic [4:0]  irq_code;

   assign pend     = mip_q & mie_r;
   assign irq_take = instr_valid && mstat_mie && (pend != 32'h0);

   always_comb begin
      irq_code = 5'd7;
      if (pend[3])  irq_code = 5'd3;
      if (pend[11]) irq_code = 5'd11;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (pend[16+i]) irq_code = 5'(16 + i);
      end
   end

   // exceptions and trap resolution
   logic        exc_take;
   logic [4:0]  exc_code;
   logic        trap_take;
   logic [4:0]  trap_code;
   logic        mret_take;
   logic        wr_en;
   logic        retire;
   logic [31:0] base;
   logic [31:0] vec_target;

   always_comb begin
      exc_code = 5'd3;
      if (illegal)                 exc_code = 5'd2;
      else if (csr_op == OP_ECALL) exc_code = 5'd11;
   end

   assign exc_take   = instr_valid && !irq_take &&
                       (illegal || (csr_op == OP_ECALL) || (csr_op == OP_EBRK));
   assign trap_take  = irq_take || exc_take;
   assign trap_code  = irq_take ? irq_code : exc_code;
   assign mret_take  = instr_valid && !irq_take && (csr_op == OP_MRET);
   assign wr_en      = instr_valid && !trap_take && is_csr && do_write;
   assign retire     = instr_valid && !trap_take;
   assign base       = {mtvec[31:2], 2'b00};
   assign vec_target = (mtvec[0] && irq_take) ? base + {25'b0, trap_code, 2'b00} : base;

   // counters: a CSR write to one half replaces the increment, the other half holds
   logic [63:0] mcycle_nx;
   logic [63:0] minstret_nx;

   always_comb begin
      mcycle_nx   = mcycle + 64'd1;
      minstret_nx = retire ? minstret + 64'd1 : minstret;
      if (wr_en) begin
         case (csr_addr)
            12'hB00: mcycle_nx   = {mcycle[63:32], new_val};
            12'hB80: mcycle_nx   = {new_val, mcycle[31:0]};
            12'hB02: minstret_nx = {minstret[63:32], new_val};
            12'hB82: minstret_nx = {new_val, minstret[31:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstat_mie   <= 1'b0;
         mstat_mpie  <= 1'b0;
         mie_r       <= '0;
         mtvec       <= RESET_VEC;
         mscratch    <= '0;
         mepc        <= '0;
         mcause      <= '0;
         mtval       <= '0;
         mip_q       <= '0;
         mcycle      <= '0;
         minstret    <= '0;
         trap_valid  <= 1'b0;
         trap_target <= '0;
      end else begin
         mip_q    <= irq_in & IRQ_MASK;
         mcycle   <= mcycle_nx;
         minstret <= minstret_nx;
         if (trap_take) begin
            mepc        <= pc & 32'hFFFF_FFFC;
            mcause      <= {irq_take, 26'b0, trap_code};
            mtval       <= '0;
            mstat_mpie  <= mstat_mie;
            mstat_mie   <= 1'b0;
            trap_valid  <= 1'b1;
            trap_target <= vec_target;
         end else if (mret_take) begin
            mstat_mie   <= mstat_mpie;
            mstat_mpie  <= 1'b1;
            trap_valid  <= 1'b1;
            trap_target <= mepc;
         end else begin
            trap_valid  <= 1'b0;
            if (wr_en) begin
               case (csr_addr)
                  12'h300: begin
                     mstat_mie  <= new_val[3];
                     mstat_mpie <= new_val[7];
                  end
                  12'h304: mie_r    <= new_val & IRQ_MASK;
                  12'h305: mtvec    <= new_val & 32'hFFFF_FFFD;
                  12'h340: mscratch <= new_val;
                  12'h341: mepc     <= new_val & 32'hFFFF_FFFC;
                  12'h342: mcause   <= new_val;
                  12'h343: mtval    <= new_val;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
module tb_csr_trap_unit;

   localparam int          NIRQ = 4;
   localparam logic [31:0] RVEC = 32'h0000_1000;
   localparam logic [31:0] MASK = 32'h0000_0888 | (((32'h1 << NIRQ) - 32'h1) << 16);
`ifdef CSR_IRQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [31:0]     pc;
   logic            instr_valid;
   logic [2:0]      csr_op;
   logic            csr_imm_sel;
   logic [4:0]      csr_zimm;
   logic [31:0]     rs1_data;
   logic [11:0]     csr_addr;
   logic            irq_sw, irq_tim, irq_ext;
   logic [NIRQ-1:0] irq_plat;
   logic [31:0]     csr_rdata;
   logic            illegal;
   logic            trap_valid;
   logic [31:0]     trap_target;

   always #5 clk = ~clk;

   csr_trap_unit #(.NUM_IRQ(NIRQ), .RESET_VEC(RVEC)) dut (
      .clk(clk), .rst(rst), .pc(pc), .instr_valid(instr_valid), .csr_op(csr_op),
      .csr_imm_sel(csr_imm_sel), .csr_zimm(csr_zimm), .rs1_data(rs1_data),
      .csr_addr(csr_addr), .irq_sw(irq_sw), .irq_tim(irq_tim), .irq_ext(irq_ext),
      .irq_plat(irq_plat), .csr_rdata(csr_rdata), .illegal(illegal),
      .trap_valid(trap_valid), .trap_target(trap_target)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        ill;
      logic        tv;
      logic [31:0] tt;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // reference model: architectural state at instruction level
   logic        m_mie_b, m_mpie;
   logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic [63:0] m_cyc, m_ret;
   logic [31:0] m_hist [3];
   logic        m_tv;
   logic [31:0] m_tt;

   // irq levels requested for the next driven cycle
   logic            n_sw = 0, n_tim = 0, n_ext = 0;
   logic [NIRQ-1:0] n_plat = '0;
   logic [31:0]     cur_pc = 32'h0;

   task automatic model_reset();
      m_mie_b = 0; m_mpie = 0; m_mie = 0; m_mtvec = RVEC; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ret = 0;
      for (int k = 0; k < 3; k++) m_hist[k] = 0;
      m_tv = 0; m_tt = 0;
   endtask

   function automatic logic csr_known(input logic [11:0] a);
      case (a)
         12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
         12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie_b ? 32'h8 : 32'h0);
         12'h301: return 32'h4000_0100;
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return m_hist[LAT-1];
         12'hB00: return m_cyc[31:0];
         12'hB80: return m_cyc[63:32];
         12'hB02: return m_ret[31:0];
         12'hB82: return m_ret[63:32];
         default: return 32'h0;
      endcase
   endfunction

   // one clock cycle: drive, predict outputs for this cycle, advance the model
   task automatic cycle(input logic iv, input logic [2:0] op, input logic isel,
                        input logic [4:0] z, input logic [31:0] rs1,
                        input logic [11:0] addr, input logic [31:0] pcv, input logic rs);
      exp_t        e;
      logic [31:0] raw, pend, old, src, nv, base;
      logic        irq, is_csr, dowrite, ro, ill, exc, trap, found;
      int          code, tcode;
      logic [63:0] cyc_n, ret_n;
      logic        tv_n;
      logic [31:0] tt_n;
      @(posedge clk);
      #1;
      rst = rs; instr_valid = iv; csr_op = op; csr_imm_sel = isel; csr_zimm = z;
      rs1_data = rs1; csr_addr = addr; pc = pcv;
      irq_sw = n_sw; irq_tim = n_tim; irq_ext = n_ext; irq_plat = n_plat;

      raw = 0; raw[3] = n_sw; raw[7] = n_tim; raw[11] = n_ext; raw[16 +: NIRQ] = n_plat;
      pend = m_hist[LAT-1] & m_mie;
      irq  = iv && m_mie_b && (pend != 0);
      code = 7; found = 0;
      for (int i = NIRQ - 1; i >= 0; i--)
         if (!found && pend[16+i]) begin code = 16 + i; found = 1; end
      if (!found) begin
         if (pend[11]) code = 11;
         else if (pend[3]) code = 3;
      end
      is_csr  = (op >= 3'd1) && (op <= 3'd3);
      old     = csr_known(addr) ? model_read(addr) : 32'h0;
      src     = isel ? {27'b0, z} : rs1;
      dowrite = (op == 3'd1) || (src != 0);
      ro      = (addr[11:10] == 2'b11) || (addr == 12'h301) || (addr == 12'h344);
      ill     = is_csr && (!csr_known(addr) || (ro && dowrite));

      e.rdata = is_csr ? old : 32'h0;
      e.ill = ill; e.tv = m_tv; e.tt = m_tt;
      q.push_back(e);

      exc   = iv && !irq && (ill || op == 3'd4 || op == 3'd5);
      trap  = irq || exc;
      tcode = irq ? code : (ill ? 2 : (op == 3'd4 ? 11 : 3));
      cyc_n = m_cyc + 64'd1;
      ret_n = m_ret + ((iv && !trap) ? 64'd1 : 64'd0);
      tv_n  = 0;
      tt_n  = m_tt;
      if (rs) begin
         model_reset();
      end else begin
         if (trap) begin
            base     = m_mtvec & 32'hFFFF_FFFC;
            tt_n     = (m_mtvec[0] && irq) ? base + 32'(4 * tcode) : base;
            tv_n     = 1;
            m_mepc   = pcv & 32'hFFFF_FFFC;
            m_mcause = (irq ? 32'h8000_0000 : 32'h0) | 32'(tcode);
            m_mtval  = 0;
            m_mpie   = m_mie_b;
            m_mie_b  = 0;
         end else if (iv && op == 3'd6) begin
            tt_n    = m_mepc;
            tv_n    = 1;
            m_mie_b = m_mpie;
            m_mpie  = 1;
         end else if (iv && is_csr && dowrite) begin
            nv = (op == 3'd1) ? src : (op == 3'd2) ? (old | src) : (old & ~src);
            case (addr)
               12'h300: begin m_mie_b = nv[3]; m_mpie = nv[7]; end
               12'h304: m_mie      = nv & MASK;
               12'h305: m_mtvec    = nv & 32'hFFFF_FFFD;
               12'h340: m_mscratch = nv;
               12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
               12'h342: m_mcause   = nv;
               12'h343: m_mtval    = nv;
               12'hB00: cyc_n = {m_cyc[63:32], nv};
               12'hB80: cyc_n = {nv, m_cyc[31:0]};
               12'hB02: ret_n = {m_ret[63:32], nv};
               12'hB82: ret_n = {nv, m_ret[31:0]};
               default: ;
            endcase
         end
         m_cyc = cyc_n; m_ret = ret_n; m_tv = tv_n; m_tt = tt_n;
         m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = raw & MASK;
      end
   endtask

   task automatic csr_rw(input logic [11:0] a, input logic [31:0] d);
      cur_pc = cur_pc + 4;
      cycle(1, 3'b001, 0, 5'd0, d, a, cur_pc, 0);
   endtask

   task automatic csr_rd(input logic [11:0] a);
      cur_pc = cur_pc + 4;
      cycle(1, 3'b010, 1, 5'd0, 32'hFFFF_FFFF, a, cur_pc, 0);
   endtask

   task automatic sys_op(input logic [2:0] op, input logic [31:0] p);
      cycle(1, op, 0, 5'd0, 32'h0, 12'h000, p, 0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(0, 3'b000, 0, 5'd0, 32'h0, 12'h000, cur_pc, 0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // monitor: one expected record per driven cycle, compared mid-cycle
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("csr_rdata", csr_rdata, e.rdata);
         chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
         chk("trap_valid", {31'b0, trap_valid}, {31'b0, e.tv});
         if (e.tv) chk("trap_target", trap_target, e.tt);
      end
   end

   logic [11:0] addr_tbl [16];

   initial begin
      addr_tbl = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                   12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'hC00};
      rst = 1; pc = 0; instr_valid = 0; csr_op = 0; csr_imm_sel = 0; csr_zimm = 0;
      rs1_data = 0; csr_addr = 0; irq_sw = 0; irq_tim = 0; irq_ext = 0; irq_plat = '0;
      model_reset();
      repeat (2) @(posedge clk);
      cycle(0, 3'b000, 0, 5'd0, 32'h0, 12'h000, 32'h0, 1);

      // reset values
      csr_rd(12'h300); csr_rd(12'h304); csr_rd(12'h305); csr_rd(12'h344);
      csr_rd(12'hF14); csr_rd(12'h301);

      // vectored external interrupt
      csr_rw(12'h305, 32'h8000_0001);
      csr_rw(12'h304, 32'h0000_0800);
      n_ext = 1;
      idle(3);
      csr_rw(12'h300, 32'h0000_0008);
      sys_op(3'b000, 32'h0000_0100);
      n_ext = 0;
      idle(3);
      csr_rd(12'h341); csr_rd(12'h342); csr_rd(12'h300);

      // platform line beats MEI; the CSRRW of the interrupted instruction is dropped
      csr_rw(12'h304, 32'h0008_0800);
      n_ext = 1; n_plat = 4'b1000;
      idle(3);
      csr_rw(12'h300, 32'h0000_0008);
      cycle(1, 3'b001, 0, 5'd0, 32'hDEAD_BEEF, 12'h340, 32'h0000_0180, 0);
      n_ext = 0; n_plat = '0;
      idle(3);
      csr_rd(12'h342); csr_rd(12'h340); csr_rd(12'hB02);

      // ECALL then MRET
      csr_rw(12'h305, 32'h0000_0400);
      sys_op(3'b100, 32'h0000_0204);
      csr_rd(12'h342);
      sys_op(3'b110, 32'h0000_0300);
      csr_rd(12'h300);
      sys_op(3'b101, 32'h0000_0310);
      csr_rd(12'h342);

      // read-only accesses
      csr_rw(12'hF14, 32'h1234_5678);
      csr_rd(12'h342);
      csr_rd(12'hF14);
      csr_rw(12'h7C0, 32'h1);

      // counter wrap and write-over-increment
      csr_rw(12'hB00, 32'hFFFF_FFFF);
      csr_rw(12'hB80, 32'hFFFF_FFFF);
      csr_rd(12'hB00); csr_rd(12'hB80); csr_rd(12'hB00);
      csr_rw(12'hB02, 32'h0000_1234);
      csr_rd(12'hB02); csr_rd(12'hB82);

      // reset arriving together with a trap cancels the pulse
      cycle(1, 3'b100, 0, 5'd0, 32'h0, 12'h000, 32'h0000_0500, 1);
      csr_rd(12'h341); csr_rd(12'h300); csr_rd(12'h305);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         logic        iv, isel, rs;
         logic [2:0]  op;
         logic [4:0]  z;
         int          r;
         if ($urandom_range(0, 7) == 0) begin
            n_sw  = ($urandom_range(0, 3) == 0);
            n_tim = ($urandom_range(0, 3) == 0);
            n_ext = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < NIRQ; b++) n_plat[b] = ($urandom_range(0, 4) == 0);
         end
         iv = ($urandom_range(0, 9) != 0);
         r  = $urandom_range(0, 19);
         if (r < 3) op = 3'b000;
         else if (r < 8) op = 3'b001;
         else if (r < 12) op = 3'b010;
         else if (r < 16) op = 3'b011;
         else if (r == 16) op = 3'b100;
         else if (r == 17) op = 3'b101;
         else op = 3'b110;
         isel = 1'($urandom_range(0, 1));
         z    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
         rs   = ($urandom_range(0, 299) == 0);
         cycle(iv, op, isel, z, $urandom, addr_tbl[$urandom_range(0, 15)], $urandom, rs);
      end

      idle(1);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
